// File: rtl/event_scheduler.sv
// Event scheduler: two circular FIFOs (neuron spikes and controller virtual
// events) with a locked head entry. Virtual events win head arbitration.
module event_scheduler #(
  parameter int M          = 8,
  parameter int SPK_DEPTH  = 64,
  parameter int VIRT_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         spk_push,
  input  logic [M-1:0] spk_addr,
  input  logic         ctrl_sched_pop_n,
  input  logic [6:0]   ctrl_sched_event_in,
  input  logic [M-1:0] ctrl_sched_addr,
  input  logic [4:0]   ctrl_sched_param,
  input  logic         sched_ovf_clr,
  output logic         sched_empty,
  output logic         sched_full,
  output logic         sched_burst_end,
  output logic [M+4:0] sched_data_out,
  output logic         sched_ovf
);

  localparam int SPK_AW  = $clog2(SPK_DEPTH);
  localparam int VIRT_AW = $clog2(VIRT_DEPTH);

  localparam logic [SPK_AW:0]    SPK_MAX       = (SPK_AW+1)'(SPK_DEPTH);
  localparam logic [SPK_AW:0]    SPK_CNT_ONE   = (SPK_AW+1)'(1);
  localparam logic [SPK_AW-1:0]  SPK_PTR_ONE   = SPK_AW'(1);
  localparam logic [VIRT_AW:0]   VIRT_MAX      = (VIRT_AW+1)'(VIRT_DEPTH);
  localparam logic [VIRT_AW:0]   VIRT_CNT_ONE  = (VIRT_AW+1)'(1);
  localparam logic [VIRT_AW-1:0] VIRT_PTR_ONE  = VIRT_AW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HEAD_VIRT = 2'd1,
    HEAD_SPK  = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [M-1:0]     spk_mem_r  [SPK_DEPTH];
  logic [M+4:0]     virt_mem_r [VIRT_DEPTH];
  logic [SPK_AW-1:0]  spk_wr_ptr_r, spk_rd_ptr_r;
  logic [VIRT_AW-1:0] virt_wr_ptr_r, virt_rd_ptr_r;
  logic [SPK_AW:0]    spk_cnt_r, spk_cnt_nxt_s;
  logic [VIRT_AW:0]   virt_cnt_r, virt_cnt_nxt_s;
  logic               ovf_r;

  logic         push_c_s, pop_s, ctrl_zero_s;
  logic         spk_pop_s, virt_pop_s;
  logic         spk_req_s, virt_req_s, spk_conflict_s;
  logic         spk_full_s, virt_full_s;
  logic         spk_wr_s, virt_wr_s, drop_s;
  logic [M-1:0] spk_wdata_s;

  // Request decode: a controller push suppresses that cycle's pop; routing by param.
  always_comb begin
    push_c_s       = ctrl_sched_event_in[6];
    pop_s          = !ctrl_sched_pop_n && !push_c_s;
    ctrl_zero_s    = (ctrl_sched_param == 5'd0);
    spk_pop_s      = pop_s && (state_r == HEAD_SPK);
    virt_pop_s     = pop_s && (state_r == HEAD_VIRT);
    spk_req_s      = spk_push || (push_c_s && ctrl_zero_s);
    virt_req_s     = push_c_s && !ctrl_zero_s;
    spk_conflict_s = spk_push && push_c_s && ctrl_zero_s;
    spk_full_s     = (spk_cnt_r == SPK_MAX);
    virt_full_s    = (virt_cnt_r == VIRT_MAX);
    // A full FIFO still accepts a write when its head leaves in the same cycle.
    spk_wr_s       = spk_req_s && (!spk_full_s || spk_pop_s);
    virt_wr_s      = virt_req_s && (!virt_full_s || virt_pop_s);
    spk_wdata_s    = spk_push ? spk_addr : ctrl_sched_addr;
    drop_s         = spk_conflict_s
                   || (spk_req_s && spk_full_s && !spk_pop_s)
                   || (virt_req_s && virt_full_s && !virt_pop_s);
  end

  // Post-update occupancy of both FIFOs.
  always_comb begin
    spk_cnt_nxt_s  = spk_cnt_r;
    virt_cnt_nxt_s = virt_cnt_r;
    case ({spk_wr_s, spk_pop_s})
      2'b10:   spk_cnt_nxt_s = spk_cnt_r + SPK_CNT_ONE;
      2'b01:   spk_cnt_nxt_s = spk_cnt_r - SPK_CNT_ONE;
      default: spk_cnt_nxt_s = spk_cnt_r;
    endcase
    case ({virt_wr_s, virt_pop_s})
      2'b10:   virt_cnt_nxt_s = virt_cnt_r + VIRT_CNT_ONE;
      2'b01:   virt_cnt_nxt_s = virt_cnt_r - VIRT_CNT_ONE;
      default: virt_cnt_nxt_s = virt_cnt_r;
    endcase
  end

  // FIFO storage; contents are don't-care until covered by the count.
  always_ff @(posedge clk) begin
    if (spk_wr_s) begin
      spk_mem_r[spk_wr_ptr_r] <= spk_wdata_s;
    end
    if (virt_wr_s) begin
      virt_mem_r[virt_wr_ptr_r] <= {ctrl_sched_param, ctrl_sched_addr};
    end
  end

  // Pointers, counts and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_wr_ptr_r  <= '0;
      spk_rd_ptr_r  <= '0;
      virt_wr_ptr_r <= '0;
      virt_rd_ptr_r <= '0;
      spk_cnt_r     <= '0;
      virt_cnt_r    <= '0;
      ovf_r         <= 1'b0;
    end else begin
      if (spk_wr_s)   spk_wr_ptr_r  <= spk_wr_ptr_r + SPK_PTR_ONE;
      if (spk_pop_s)  spk_rd_ptr_r  <= spk_rd_ptr_r + SPK_PTR_ONE;
      if (virt_wr_s)  virt_wr_ptr_r <= virt_wr_ptr_r + VIRT_PTR_ONE;
      if (virt_pop_s) virt_rd_ptr_r <= virt_rd_ptr_r + VIRT_PTR_ONE;
      spk_cnt_r  <= spk_cnt_nxt_s;
      virt_cnt_r <= virt_cnt_nxt_s;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop_s)             ovf_r <= 1'b1;
      else if (sched_ovf_clr) ovf_r <= 1'b0;
    end
  end

  // Head FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Head FSM next state: lock the source until popped, then re-arbitrate virtual first.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (virt_cnt_r != '0)     state_nxt_s = HEAD_VIRT;
        else if (spk_cnt_r != '0) state_nxt_s = HEAD_SPK;
        else                      state_nxt_s = IDLE;
      end
      HEAD_VIRT, HEAD_SPK: begin
        if (pop_s) begin
          if (virt_cnt_nxt_s != '0)     state_nxt_s = HEAD_VIRT;
          else if (spk_cnt_nxt_s != '0) state_nxt_s = HEAD_SPK;
          else                          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Head FSM outputs; all derived from registered state only.
  always_comb begin
    sched_empty     = (state_r == IDLE);
    sched_full      = spk_full_s || virt_full_s;
    sched_ovf       = ovf_r;
    sched_burst_end = (state_r != IDLE) &&
                      (((spk_cnt_r == SPK_CNT_ONE) && (virt_cnt_r == '0)) ||
                       ((virt_cnt_r == VIRT_CNT_ONE) && (spk_cnt_r == '0)));
    case (state_r)
      HEAD_VIRT: sched_data_out = virt_mem_r[virt_rd_ptr_r];
      HEAD_SPK:  sched_data_out = {5'd0, spk_mem_r[spk_rd_ptr_r]};
      default:   sched_data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_event_scheduler.sv
// Directed self-checking bench for event_scheduler.
module tb_event_scheduler;

  logic        clk;
  logic        rst_n;
  logic        spk_push;
  logic [7:0]  spk_addr;
  logic        ctrl_sched_pop_n;
  logic [6:0]  ctrl_sched_event_in;
  logic [7:0]  ctrl_sched_addr;
  logic [4:0]  ctrl_sched_param;
  logic        sched_ovf_clr;
  logic        sched_empty;
  logic        sched_full;
  logic        sched_burst_end;
  logic [12:0] sched_data_out;
  logic        sched_ovf;

  int checks;
  int errors;

  event_scheduler dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .spk_push            (spk_push),
    .spk_addr            (spk_addr),
    .ctrl_sched_pop_n    (ctrl_sched_pop_n),
    .ctrl_sched_event_in (ctrl_sched_event_in),
    .ctrl_sched_addr     (ctrl_sched_addr),
    .ctrl_sched_param    (ctrl_sched_param),
    .sched_ovf_clr       (sched_ovf_clr),
    .sched_empty         (sched_empty),
    .sched_full          (sched_full),
    .sched_burst_end     (sched_burst_end),
    .sched_data_out      (sched_data_out),
    .sched_ovf           (sched_ovf)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    spk_push            = 1'b0;
    spk_addr            = 8'h00;
    ctrl_sched_pop_n    = 1'b1;
    ctrl_sched_event_in = 7'h00;
    ctrl_sched_addr     = 8'h00;
    ctrl_sched_param    = 5'd0;
    sched_ovf_clr       = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #2;

    // Reset values
    check("rst_empty", 32'(sched_empty), 32'd1);
    check("rst_full",  32'(sched_full),  32'd0);
    check("rst_burst", 32'(sched_burst_end), 32'd0);
    check("rst_data",  32'(sched_data_out), 32'h0);
    check("rst_ovf",   32'(sched_ovf),   32'd0);

    // Single spike: visible one edge after it is written
    spk_push = 1'b1; spk_addr = 8'h12;
    tick();
    idle_inputs();
    check("lat_empty_k", 32'(sched_empty), 32'd1);
    tick();
    check("lat_empty_k1", 32'(sched_empty), 32'd0);
    check("lat_data",  32'(sched_data_out), 32'h0012);
    check("lat_burst", 32'(sched_burst_end), 32'd1);
    ctrl_sched_pop_n = 1'b0;
    tick();
    idle_inputs();
    check("pop1_empty", 32'(sched_empty), 32'd1);
    check("pop1_data",  32'(sched_data_out), 32'h0);

    // Spike head stays locked while a virtual event arrives
    spk_push = 1'b1; spk_addr = 8'h05;
    tick();
    idle_inputs();
    ctrl_sched_event_in = 7'h40; ctrl_sched_addr = 8'h33; ctrl_sched_param = 5'd3;
    tick();
    idle_inputs();
    check("lock_data0", 32'(sched_data_out), 32'h0005);
    tick();
    check("lock_data1", 32'(sched_data_out), 32'h0005);
    check("lock_burst", 32'(sched_burst_end), 32'd0);
    ctrl_sched_pop_n = 1'b0;
    tick();
    idle_inputs();
    check("virt_data",  32'(sched_data_out), 32'h0333);
    check("virt_burst", 32'(sched_burst_end), 32'd1);
    ctrl_sched_pop_n = 1'b0;
    tick();
    idle_inputs();
    check("virt_pop_empty", 32'(sched_empty), 32'd1);
    check("virt_pop_data",  32'(sched_data_out), 32'h0);

    // Virtual wins arbitration from idle when both arrive together
    spk_push = 1'b1; spk_addr = 8'h44;
    ctrl_sched_event_in = 7'h40; ctrl_sched_addr = 8'h55; ctrl_sched_param = 5'd5;
    tick();
    idle_inputs();
    tick();
    check("prio_virt", 32'(sched_data_out), 32'h0555);
    ctrl_sched_pop_n = 1'b0;
    tick();
    check("prio_spk", 32'(sched_data_out), 32'h0044);
    tick();
    idle_inputs();
    check("prio_empty", 32'(sched_empty), 32'd1);

    // Fill spike FIFO with addresses 0..63
    for (int i = 0; i < 64; i++) begin
      spk_push = 1'b1; spk_addr = 8'(i);
      if (i == 63) check("full_before_last", 32'(sched_full), 32'd0);
      tick();
    end
    idle_inputs();
    check("full_set", 32'(sched_full), 32'd1);
    check("full_ovf0", 32'(sched_ovf), 32'd0);
    check("full_head", 32'(sched_data_out), 32'h0000);
    spk_push = 1'b1; spk_addr = 8'hAA;
    tick();
    idle_inputs();
    check("ovf_set",   32'(sched_ovf),  32'd1);
    check("ovf_full",  32'(sched_full), 32'd1);
    sched_ovf_clr = 1'b1;
    tick();
    idle_inputs();
    check("ovf_clr", 32'(sched_ovf), 32'd0);
    // Push into full FIFO together with a pop: accepted, stays full
    spk_push = 1'b1; spk_addr = 8'hBB; ctrl_sched_pop_n = 1'b0;
    tick();
    idle_inputs();
    check("pp_full", 32'(sched_full), 32'd1);
    check("pp_ovf",  32'(sched_ovf),  32'd0);
    check("pp_head", 32'(sched_data_out), 32'h0001);
    // Back-to-back drain: 1..63 then 0xBB (the dropped 0xAA never appears)
    ctrl_sched_pop_n = 1'b0;
    tick();
    check("drain_notfull", 32'(sched_full), 32'd0);
    check("drain_2", 32'(sched_data_out), 32'h0002);
    for (int j = 3; j < 64; j++) begin
      tick();
      check("drain_seq", 32'(sched_data_out), 32'(j));
    end
    tick();
    check("drain_bb", 32'(sched_data_out), 32'h00BB);
    check("drain_bb_burst", 32'(sched_burst_end), 32'd1);
    tick();
    idle_inputs();
    check("drain_empty", 32'(sched_empty), 32'd1);

    // Spike-FIFO write conflict: core spike wins, controller event dropped
    spk_push = 1'b1; spk_addr = 8'h01;
    ctrl_sched_event_in = 7'h40; ctrl_sched_addr = 8'h02; ctrl_sched_param = 5'd0;
    tick();
    idle_inputs();
    check("conf_ovf", 32'(sched_ovf), 32'd1);
    tick();
    check("conf_data",  32'(sched_data_out), 32'h0001);
    check("conf_burst", 32'(sched_burst_end), 32'd1);
    sched_ovf_clr = 1'b1;
    tick();
    idle_inputs();
    check("conf_clr", 32'(sched_ovf), 32'd0);
    // Drop coinciding with clear: flag stays set
    spk_push = 1'b1; spk_addr = 8'h01;
    ctrl_sched_event_in = 7'h40; ctrl_sched_addr = 8'h02; ctrl_sched_param = 5'd0;
    sched_ovf_clr = 1'b1;
    tick();
    idle_inputs();
    check("set_over_clr", 32'(sched_ovf), 32'd1);
    sched_ovf_clr = 1'b1;
    ctrl_sched_pop_n = 1'b0;
    tick();
    check("conf2_data", 32'(sched_data_out), 32'h0001);
    tick();
    idle_inputs();
    check("conf2_empty", 32'(sched_empty), 32'd1);
    check("conf2_ovf", 32'(sched_ovf), 32'd0);

    // Push has precedence over pop in the same cycle
    spk_push = 1'b1; spk_addr = 8'h09;
    tick();
    idle_inputs();
    tick();
    check("pp_head9", 32'(sched_data_out), 32'h0009);
    ctrl_sched_pop_n = 1'b0;
    ctrl_sched_event_in = 7'h40; ctrl_sched_addr = 8'h07; ctrl_sched_param = 5'd0;
    tick();
    idle_inputs();
    check("nopop_data",  32'(sched_data_out), 32'h0009);
    check("nopop_burst", 32'(sched_burst_end), 32'd0);
    ctrl_sched_pop_n = 1'b0;
    tick();
    idle_inputs();
    check("nopop_next", 32'(sched_data_out), 32'h0007);
    ctrl_sched_pop_n = 1'b0;
    tick();
    check("nopop_empty", 32'(sched_empty), 32'd1);
    // Pop while empty is ignored
    tick();
    idle_inputs();
    check("idlepop_empty", 32'(sched_empty), 32'd1);
    check("idlepop_data",  32'(sched_data_out), 32'h0);
    check("idlepop_ovf",   32'(sched_ovf), 32'd0);
    tick();
    check("idlepop_stay", 32'(sched_empty), 32'd1);

    // Asynchronous reset with 10 entries queued
    for (int i = 0; i < 10; i++) begin
      spk_push = 1'b1; spk_addr = 8'(8'h20 + i);
      tick();
    end
    idle_inputs();
    check("pre_rst_data", 32'(sched_data_out), 32'h0020);
    rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(sched_empty), 32'd1);
    check("arst_full",  32'(sched_full),  32'd0);
    check("arst_data",  32'(sched_data_out), 32'h0);
    check("arst_burst", 32'(sched_burst_end), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_empty", 32'(sched_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
